// File: rtl/wb_arb_pkg.sv
// Shared state encoding and owner-index helpers for the Wishbone DMA arbiter.
package wb_arb_pkg;

    typedef enum logic [2:0] {
        StCpu,
        StDrain,
        StGap1,
        StDma,
        StGap2
    } arb_state_e;

    localparam logic [3:0] OWNER_CPU = 4'd0;

    // Bus-mux select for DMA requester idx: 0 is reserved for the CPU.
    function automatic logic [3:0] idx_to_owner(input logic [2:0] idx);
        return {1'b0, idx} + 4'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NDMA = 2,
    localparam int unsigned IW = (NDMA > 1) ? $clog2(NDMA) : 1
) (
    input  logic [NDMA-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   winner_o,
    output logic            valid_o
);

    int unsigned     idx;
    logic [IW-1:0]   sel;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int unsigned k = 1; k <= NDMA; k++) begin
            idx = (32'(ptr_i) + k) % NDMA;
            sel = IW'(idx);
            if (!valid_o && req_i[sel]) begin
                valid_o  = 1'b1;
                winner_o = sel;
            end
        end
    end

endmodule

// File: rtl/wb_dma_arbiter.sv
// Shares the processor Wishbone bus between the CPU and NDMA DMA requesters, with a guaranteed
// CPU slot between DMA tenures and a hold-time watchdog that never cuts a cycle in flight.
module wb_dma_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NDMA     = 2,
    parameter int unsigned CPU_SLOT = 4,
    parameter int unsigned MAX_HOLD = 1024
) (
    input  logic            clk_p,
    input  logic            rst,
    input  logic            cpu_cyc_i,
    output logic            cpu_gnt_o,
    input  logic [NDMA-1:0] dma_req_i,
    input  logic [NDMA-1:0] dma_cyc_i,
    output logic [NDMA-1:0] dma_gnt_o,
    output logic [3:0]      owner_o,
    output logic            abort_o,
    output logic [2:0]      abort_id_o
);

    localparam int unsigned IW = (NDMA > 1) ? $clog2(NDMA) : 1;
    localparam int unsigned SW = $clog2(CPU_SLOT + 2);
    localparam int unsigned HW = $clog2(MAX_HOLD + 2);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(CPU_SLOT);
    localparam logic [SW-1:0] SLOT_LAST = SW'((CPU_SLOT == 0) ? 0 : CPU_SLOT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

    arb_state_e      state_q;
    logic [SW-1:0]   slot_q;
    logic [HW-1:0]   hold_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   win_q;
    logic [NDMA-1:0] mask_q;
    logic            cpu_gnt_q;
    logic [NDMA-1:0] dma_gnt_q;
    logic [3:0]      owner_q;
    logic            abort_q;
    logic [2:0]      abort_id_q;

    logic [NDMA-1:0] req_masked;
    logic            any_req;
    logic            slot_ok;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            win_req;
    logic            win_cyc;

    assign req_masked = dma_req_i & ~mask_q;
    assign any_req    = |req_masked;
    // slot_q counts completed CPU cycles, so handover happens at the end of the CPU_SLOT-th one.
    assign slot_ok    = (slot_q >= SLOT_LAST);
    assign win_req    = dma_req_i[win_q];
    assign win_cyc    = dma_cyc_i[win_q];

    rr_pick #(
        .NDMA(NDMA)
    ) u_pick (
        .req_i    (req_masked),
        .ptr_i    (rr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            state_q    <= StCpu;
            slot_q     <= '0;
            hold_q     <= '0;
            rr_q       <= IW'(NDMA - 1);
            win_q      <= '0;
            mask_q     <= '0;
            cpu_gnt_q  <= 1'b1;
            dma_gnt_q  <= '0;
            owner_q    <= OWNER_CPU;
            abort_q    <= 1'b0;
            abort_id_q <= '0;
        end else begin
            abort_q <= 1'b0;
            mask_q  <= mask_q & dma_req_i;
            unique case (state_q)
                StCpu: begin
                    if (slot_q != SLOT_MAX) slot_q <= slot_q + 1'b1;
                    if (slot_ok && any_req) begin
                        // An idle CPU skips DRAIN so the grant lands two cycles after the request.
                        if (!cpu_cyc_i) begin
                            state_q   <= StGap1;
                            cpu_gnt_q <= 1'b0;
                        end else begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!cpu_cyc_i) begin
                        state_q   <= StGap1;
                        cpu_gnt_q <= 1'b0;
                    end
                end
                StGap1: begin
                    hold_q <= '0;
                    if (pick_valid) begin
                        state_q   <= StDma;
                        win_q     <= pick_idx;
                        rr_q      <= pick_idx;
                        dma_gnt_q <= NDMA'(1) << pick_idx;
                        owner_q   <= idx_to_owner(3'(pick_idx));
                    end else begin
                        state_q <= StGap2;
                    end
                end
                StDma: begin
                    if (hold_q != HOLD_MAX) hold_q <= hold_q + 1'b1;
                    if (!win_req && !win_cyc) begin
                        state_q   <= StGap2;
                        dma_gnt_q <= '0;
                        owner_q   <= OWNER_CPU;
                    end else if (hold_q == HOLD_MAX && !win_cyc) begin
                        state_q    <= StGap2;
                        dma_gnt_q  <= '0;
                        owner_q    <= OWNER_CPU;
                        abort_q    <= 1'b1;
                        abort_id_q <= 3'(win_q);
                        mask_q     <= (mask_q & dma_req_i) | (NDMA'(1) << win_q);
                    end
                end
                StGap2: begin
                    state_q   <= StCpu;
                    cpu_gnt_q <= 1'b1;
                    owner_q   <= OWNER_CPU;
                    slot_q    <= '0;
                end
                default: state_q <= StCpu;
            endcase
        end
    end

    assign cpu_gnt_o  = cpu_gnt_q;
    assign dma_gnt_o  = dma_gnt_q;
    assign owner_o    = owner_q;
    assign abort_o    = abort_q;
    assign abort_id_o = abort_id_q;

endmodule
